// File: rtl/niosii_nios2_cpu_debug_cmd_bridge.sv
// rtl/niosii_nios2_cpu_debug_cmd_bridge.sv - sysclk command bridge for the Nios II JTAG debug slave
// Synchronises TCK-side scan strobes, queues completed DR scans and pulses per-channel actions on dequeue.
module niosii_nios2_cpu_debug_cmd_bridge #(
  parameter  int IR_WIDTH    = 2,
  parameter  int DR_WIDTH    = 38,
  parameter  int ACT_BIT     = 34,
  parameter  int SYNC_STAGES = 2,
  parameter  int FIFO_DEPTH  = 4,
  localparam int NUM_CH      = 1 << IR_WIDTH,
  localparam int PTR_W       = $clog2(FIFO_DEPTH),
  localparam int LVL_W       = PTR_W + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [DR_WIDTH-1:0] sr,
  input  logic                vs_uir,
  input  logic                vs_e1dr,
  input  logic                cmd_ready,
  input  logic                ovf_clr,
  output logic                cmd_valid,
  output logic [IR_WIDTH-1:0] cmd_ch,
  output logic [DR_WIDTH-1:0] jdo,
  output logic [NUM_CH-1:0]   take_action,
  output logic [NUM_CH-1:0]   take_no_action,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                overflow
);

  logic [SYNC_STAGES-1:0] uir_sync_q, e1dr_sync_q, prime_q;
  logic                   uir_dly_q, e1dr_dly_q;
  logic                   uir_arm_q, uir_arm_d, e1dr_arm_q, e1dr_arm_d;
  logic                   uir_s, e1dr_s, primed, uir_p, e1dr_p;

  logic [IR_WIDTH-1:0]    ir_code_q, ir_code_d;
  logic [IR_WIDTH-1:0]    ch_mem  [FIFO_DEPTH];
  logic [DR_WIDTH-1:0]    dat_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       count_q, count_d;
  logic [DR_WIDTH-1:0]    jdo_q, jdo_d, head_dat;
  logic [NUM_CH-1:0]      ta_q, ta_d, tna_q, tna_d, ch_onehot;
  logic                   ovf_q, ovf_d;
  logic                   full, pop, push_ok, drop;

  assign uir_s  = uir_sync_q[SYNC_STAGES-1];
  assign e1dr_s = e1dr_sync_q[SYNC_STAGES-1];
  assign primed = prime_q[SYNC_STAGES-1];

  // A strobe only counts as an edge once a genuine low has been seen after reset,
  // so a level already high when reset releases never produces a pulse.
  assign uir_p  = uir_s & ~uir_dly_q & uir_arm_q;
  assign e1dr_p = e1dr_s & ~e1dr_dly_q & e1dr_arm_q;

  assign head_dat  = dat_mem[rd_ptr_q];
  assign cmd_ch    = ch_mem[rd_ptr_q];
  assign ch_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << cmd_ch;

  assign full      = (count_q == LVL_W'(FIFO_DEPTH));
  assign cmd_valid = (count_q != '0);
  assign pop       = cmd_valid & cmd_ready;
  assign push_ok   = e1dr_p & (~full | pop);
  assign drop      = e1dr_p & full & ~pop;

  always_comb begin
    uir_arm_d  = uir_arm_q | (primed & ~uir_s);
    e1dr_arm_d = e1dr_arm_q | (primed & ~e1dr_s);
    ir_code_d  = ir_code_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    jdo_d      = jdo_q;
    ta_d       = '0;
    tna_d      = '0;
    ovf_d      = ovf_q;

    if (uir_p) ir_code_d = ir_in;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      jdo_d    = head_dat;
      if (head_dat[ACT_BIT]) ta_d  = ch_onehot;
      else                   tna_d = ch_onehot;
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_q  <= '0;
      e1dr_sync_q <= '0;
      prime_q     <= '0;
      uir_dly_q   <= 1'b0;
      e1dr_dly_q  <= 1'b0;
      uir_arm_q   <= 1'b0;
      e1dr_arm_q  <= 1'b0;
      ir_code_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      jdo_q       <= '0;
      ta_q        <= '0;
      tna_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      e1dr_sync_q <= {e1dr_sync_q[SYNC_STAGES-2:0], vs_e1dr};
      prime_q     <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      uir_dly_q   <= uir_s;
      e1dr_dly_q  <= e1dr_s;
      uir_arm_q   <= uir_arm_d;
      e1dr_arm_q  <= e1dr_arm_d;
      ir_code_q   <= ir_code_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      jdo_q       <= jdo_d;
      ta_q        <= ta_d;
      tna_q       <= tna_d;
      ovf_q       <= ovf_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers and counter.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      ch_mem[wr_ptr_q]  <= ir_code_q;
      dat_mem[wr_ptr_q] <= sr;
    end
  end

  assign ir_q           = ir_code_q;
  assign jdo            = jdo_q;
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign fifo_level     = count_q;
  assign overflow       = ovf_q;

endmodule

// File: doc/niosii_nios2_cpu_debug_cmd_bridge.md
# niosii_nios2_cpu_debug_cmd_bridge

Parametrised system-clock command bridge for the Nios II JTAG debug slave. It synchronises the update-IR and exit1-DR indications from the TCK side, captures the IR code and the DR shift register, and buffers each completed DR scan in a FIFO. On dequeue it issues one-cycle take-action / take-no-action pulses per IR channel and presents the scan data on `jdo`. It replaces the fixed 2-bit-IR, 38-bit, unbuffered sysclk decoder and sits between the virtual-JTAG TCK logic and the OCI break, ocimem and trace-control units.

## Interface
Parameters:
- IR_WIDTH, 2, IR code width; channel count NUM_CH = 2**IR_WIDTH
- DR_WIDTH, 38, DR shift-register and `jdo` width
- ACT_BIT, 34, bit of `sr` that selects action (1) vs no-action (0); must be < DR_WIDTH
- SYNC_STAGES, 2, synchroniser depth for `vs_uir`/`vs_e1dr`; minimum 2
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2

Ports:
- clk  in  1  system clock; only clock of the block
- reset_n  in  1  asynchronous active-low reset
- ir_in  in  IR_WIDTH  IR code from TCK domain; quasi-static around `vs_uir`
- sr  in  DR_WIDTH  DR shift register from TCK domain; quasi-static around `vs_e1dr`
- vs_uir  in  1  update-IR level, asynchronous to clk
- vs_e1dr  in  1  exit1-DR level, asynchronous to clk
- cmd_ready  in  1  consumer accepts the head entry
- ovf_clr  in  1  clears `overflow`
- cmd_valid  out  1  FIFO non-empty
- cmd_ch  out  IR_WIDTH  IR code of the head entry
- jdo  out  DR_WIDTH  data of the most recently dequeued entry
- take_action  out  NUM_CH  one-hot pulse; channel of the dequeued entry, action bit 1
- take_no_action  out  NUM_CH  one-hot pulse; channel of the dequeued entry, action bit 0
- ir_q  out  IR_WIDTH  last IR code captured on update-IR
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when a scan is dropped

## Operation
- Reset (asynchronous, active-low) clears all synchroniser flops, edge registers, FIFO pointers, `ir_q`, `jdo`, `take_action`, `take_no_action` and `overflow`. Outputs read 0 and `fifo_level` reads 0.
- Each of `vs_uir` and `vs_e1dr` passes through a SYNC_STAGES-deep flop chain followed by one delay flop. uir_p and e1dr_p are the rising-edge pulses (synced & ~delayed). A level held high produces exactly one pulse.
- uir_p: `ir_q` <= `ir_in`.
- e1dr_p: push the entry {`ir_q`, `sr`}. If uir_p fires in the same cycle, the entry uses the old `ir_q`.
- Pop occurs when `cmd_valid` & `cmd_ready`. The block then registers `jdo` <= entry data and drives a one-cycle pulse on either `take_action[ch]` (entry bit ACT_BIT = 1) or `take_no_action[ch]` (entry bit ACT_BIT = 0). All other bits are 0. `jdo` holds its value until the next pop.
- Full FIFO with push and no pop: the push is dropped, `overflow` is set, and FIFO contents are unchanged.
- Full FIFO with push and pop in the same cycle: both are accepted and the level is unchanged.
- Empty FIFO with push and pop in the same cycle: the pop is ignored because `cmd_valid` is 0. The push is accepted.
- `ovf_clr` clears `overflow`. If a drop occurs in the same cycle, set wins.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. `fifo_level` is computed from a separate counter, with no wrap ambiguity.
- `cmd_ch` is combinational from the head entry. Its value is don't-care while `cmd_valid`=0.

## Timing
- Capture latency: `vs_e1dr` is first sampled high at edge 1 and e1dr_p is high between edges SYNC_STAGES and SYNC_STAGES+1. The FIFO write occurs at edge SYNC_STAGES+1, and `cmd_valid` is high after that edge when the FIFO was empty (edge 3 for the default).
- `ir_q` updates at edge SYNC_STAGES+1 after `vs_uir` is first sampled high.
- Pop at edge k: `jdo` and the pulse are both valid in the cycle after edge k, and the pulse drops after edge k+1.
- With `cmd_ready` held high, the sustained rate is one pop per clock.
- Minimum spacing between two `vs_e1dr` rising edges is SYNC_STAGES+2 clk periods low plus high. Closer spacing is an upstream violation and the result is undefined.
- Reset asserted mid-operation discards queued entries and any in-flight pulse immediately. The first pulse after deassertion requires a fresh rising edge.

## Test plan
- Reset: assert `reset_n`=0 mid-traffic -> all outputs 0 and `fifo_level`=0 without waiting for a clk edge; after release, a held-high `vs_e1dr` produces no entry.
- Single scan (defaults): `ir_in`=2, pulse `vs_uir`, then `sr[34]`=1, `sr`=38'h4_0000_00AB, raise `vs_e1dr` with `cmd_ready`=1 -> `cmd_valid` after edge 3, `cmd_ch`=2, `take_action`=4'b0100 for exactly one cycle, `jdo`=38'h4_0000_00AB.
- No-action path: same as the single scan with `sr[34]`=0, `ir_in`=1 -> `take_no_action`=4'b0010 and `take_action`=0.
- Overflow: `cmd_ready`=0, 5 scans -> `fifo_level`=4 and `overflow`=1. Draining returns the first 4 scans in order and the 5th is absent. `ovf_clr` -> `overflow`=0.
- Simultaneous events: full FIFO with push+pop in the same cycle -> level stays 4 and `overflow` stays 0. uir_p and e1dr_p in the same cycle -> the entry carries the old `ir_q`.
- Parameter sweep: IR_WIDTH=3, DR_WIDTH=40, FIFO_DEPTH=8, SYNC_STAGES=3 -> 8-channel one-hot pulses, capture latency 4 edges, and pointer wrap verified over 20 scans.
